csel_adder_pipe: RTL

- Parametrised, pipelined carry-select adder/subtractor. Successor to the 4-bit combinational carry-select adder.
- Operands are split into NBLK = WIDTH/BLK blocks. Stage 0 precomputes every block's sum and carry-out for carry-in 0 and for carry-in 1. Each later stage resolves one block's select.
- Valid/ready streaming interface with backpressure. Sits between operand registers and the result bus in the adder/multiplier comparison datapath.

---
 rtl/csel_adder_pipe_if.sv | 34 +++
 rtl/csel_adder_pipe.sv | 134 +++++++++++++
 2 files changed

// File: rtl/csel_adder_pipe_if.sv
// Stream bus for csel_adder_pipe: operand beat in, registered result out.
// out_ovf exists only when CSEL_ADDER_PIPE_OVF_EN is defined.
interface csel_adder_pipe_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   out_sum;
`ifdef CSEL_ADDER_PIPE_OVF_EN
   logic             out_ovf;
`endif

   modport master (
`ifdef CSEL_ADDER_PIPE_OVF_EN
      input  out_ovf,
`endif
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum
   );

   modport slave (
`ifdef CSEL_ADDER_PIPE_OVF_EN
      output out_ovf,
`endif
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum
   );
endinterface

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: stage 0 precomputes both block sums, each later stage resolves one block.
// Optional signed-overflow output enabled by defining CSEL_ADDER_PIPE_OVF_EN.
module csel_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   csel_adder_pipe_if.slave   bus
);
   localparam int NBLK = WIDTH / BLK;

   // One shared advance: the whole pipe moves or the whole pipe holds.
   logic adv;

   logic [WIDTH-1:0] b_c;
   logic             c_c;
   logic [WIDTH-1:0] s0_c;
   logic [WIDTH-1:0] s1_c;
   logic [NBLK-1:0]  c0_c;
   logic [NBLK-1:0]  c1_c;
   logic [WIDTH-1:0] sum0_c;
   logic             r0_c;

   logic             vld_p [NBLK];
   logic [WIDTH-1:0] s0_p  [NBLK];
   logic [WIDTH-1:0] s1_p  [NBLK];
   logic [NBLK-1:0]  c0_p  [NBLK];
   logic [NBLK-1:0]  c1_p  [NBLK];
   logic [WIDTH-1:0] sum_p [NBLK];
   logic             r_p   [NBLK];
   logic [WIDTH-1:0] sum_n [NBLK];
   logic             r_n   [NBLK];
`ifdef CSEL_ADDER_PIPE_OVF_EN
   logic             sa_p  [NBLK];
   logic             sb_p  [NBLK];
`endif

   function automatic logic [BLK:0] ripple(input logic [BLK-1:0] a,
                                           input logic [BLK-1:0] b,
                                           input logic           ci);
      logic [BLK-1:0] s;
      logic           c;
      c = ci;
      for (int i = 0; i < BLK; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
      return {c, s};
   endfunction

   assign adv           = !vld_p[NBLK-1] || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_p[NBLK-1];
   assign bus.out_sum   = {r_p[NBLK-1], sum_p[NBLK-1]};
`ifdef CSEL_ADDER_PIPE_OVF_EN
   assign bus.out_ovf   = (sa_p[NBLK-1] == sb_p[NBLK-1]) &&
                          (sum_p[NBLK-1][WIDTH-1] != sa_p[NBLK-1]);
`endif

   // Stage 0 inputs: operand conditioning and both speculative block results.
   always_comb begin
      b_c    = bus.in_sub ? ~bus.in_b : bus.in_b;
      c_c    = bus.in_sub | bus.in_cin;
      s0_c   = '0;
      s1_c   = '0;
      c0_c   = '0;
      c1_c   = '0;
      for (int k = 0; k < NBLK; k++) begin
         {c0_c[k], s0_c[k*BLK +: BLK]} = ripple(bus.in_a[k*BLK +: BLK], b_c[k*BLK +: BLK], 1'b0);
         {c1_c[k], s1_c[k*BLK +: BLK]} = ripple(bus.in_a[k*BLK +: BLK], b_c[k*BLK +: BLK], 1'b1);
      end
      sum0_c            = '0;
      sum0_c[BLK-1:0]   = c_c ? s1_c[BLK-1:0] : s0_c[BLK-1:0];
      r0_c              = c_c ? c1_c[0] : c0_c[0];
   end

   // Stage j inputs: select block j from the running carry of stage j-1.
   always_comb begin
      for (int j = 0; j < NBLK; j++) begin
         sum_n[j] = sum0_c;
         r_n[j]   = r0_c;
      end
      for (int j = 1; j < NBLK; j++) begin
         sum_n[j]                  = sum_p[j-1];
         sum_n[j][j*BLK +: BLK]    = r_p[j-1] ? s1_p[j-1][j*BLK +: BLK] : s0_p[j-1][j*BLK +: BLK];
         r_n[j]                    = r_p[j-1] ? c1_p[j-1][j] : c0_p[j-1][j];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int j = 0; j < NBLK; j++) begin
            vld_p[j] <= 1'b0;
            s0_p[j]  <= '0;
            s1_p[j]  <= '0;
            c0_p[j]  <= '0;
            c1_p[j]  <= '0;
            sum_p[j] <= '0;
            r_p[j]   <= 1'b0;
`ifdef CSEL_ADDER_PIPE_OVF_EN
            sa_p[j]  <= 1'b0;
            sb_p[j]  <= 1'b0;
`endif
         end
      end else if (adv) begin
         // in_ready equals adv, so an offered beat is always taken here.
         vld_p[0] <= bus.in_valid;
         s0_p[0]  <= s0_c;
         s1_p[0]  <= s1_c;
         c0_p[0]  <= c0_c;
         c1_p[0]  <= c1_c;
`ifdef CSEL_ADDER_PIPE_OVF_EN
         sa_p[0]  <= bus.in_a[WIDTH-1];
         sb_p[0]  <= b_c[WIDTH-1];
`endif
         for (int j = 1; j < NBLK; j++) begin
            vld_p[j] <= vld_p[j-1];
            s0_p[j]  <= s0_p[j-1];
            s1_p[j]  <= s1_p[j-1];
            c0_p[j]  <= c0_p[j-1];
            c1_p[j]  <= c1_p[j-1];
`ifdef CSEL_ADDER_PIPE_OVF_EN
            sa_p[j]  <= sa_p[j-1];
            sb_p[j]  <= sb_p[j-1];
`endif
         end
         for (int j = 0; j < NBLK; j++) begin
            sum_p[j] <= sum_n[j];
            r_p[j]   <= r_n[j];
         end
      end
   end
endmodule
